// File: rtl/axi_data_mem_slave.sv
// axi_data_mem_slave: AXI4 memory responder modelling the mcu data memory.
// Serves one transaction at a time (single-beat or INCR burst, read or write)
// from a word-addressed array. Beats that fall outside the array get SLVERR.
// Optional macro AXI_DATA_MEM_WSTRB_EN: honour wstrb byte lanes on writes.
// Without it, every write beat stores the full word.
// Only a 32-bit data width is supported.
module axi_data_mem_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int MEM_WORDS          = 1024
) (
  input  logic                              clk,
  input  logic                              reset_n,
  // write address
  input  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic [2:0]                        s_axi_awsize,
  input  logic [1:0]                        s_axi_awburst,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  // write data
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  // write response
  output logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  // read address
  input  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  input  logic [2:0]                        s_axi_arsize,
  input  logic [1:0]                        s_axi_arburst,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  // read data
  output logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rlast,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic                              slave_busy
);

  localparam int WAW = C_S_AXI_ADDR_WIDTH - 2;  // word address width
  localparam int MAW = $clog2(MEM_WORDS);        // array index width
  localparam int NB  = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;

  state_e                      state_q, state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [WAW-1:0]              addr_q, addr_d;
  logic [7:0]                  len_q, len_d;
  logic [7:0]                  beat_q, beat_d;
  logic                        err_q, err_d;
  logic                        last_rd_q, last_rd_d;  // last served channel was read

  logic [WAW-1:0] idx;
  logic [MAW-1:0] midx;
  logic           in_range;
  logic           is_last;
  logic           mem_we;

  // Zero at time 0; deliberately never cleared by reset.
  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_WORDS] = '{default: '0};

  // Size/burst type are ignored (always INCR of 4-byte beats); byte offset unused.
  logic unused_ok;
`ifdef AXI_DATA_MEM_WSTRB_EN
  assign unused_ok = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                       s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
  assign unused_ok = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                       s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb};
`endif

  // Beat word index: no wrap, so a burst can run off the end of the array.
  assign idx        = addr_q + WAW'(beat_q);
  assign midx       = idx[MAW-1:0];
  assign in_range   = (idx < WAW'(MEM_WORDS));
  assign is_last    = (beat_q == len_q);
  assign slave_busy = (state_q != IDLE);

  // State and transaction context registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      last_rd_q <= 1'b1;  // write wins the first tie after reset
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      last_rd_q <= last_rd_d;
    end
  end

  // Next-state, arbitration and channel outputs
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    err_d         = err_q;
    last_rd_d     = last_rd_q;
    mem_we        = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bid     = '0;
    s_axi_bresp   = 2'b00;
    s_axi_rvalid  = 1'b0;
    s_axi_rid     = '0;
    s_axi_rdata   = '0;
    s_axi_rresp   = 2'b00;
    s_axi_rlast   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie, serve the channel opposite the one served last.
        if (s_axi_awvalid && (!s_axi_arvalid || last_rd_q)) begin
          s_axi_awready = 1'b1;
          id_d          = s_axi_awid;
          addr_d        = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
          len_d         = s_axi_awlen;
          beat_d        = '0;
          err_d         = 1'b0;
          last_rd_d     = 1'b0;
          state_d       = WR_DATA;
        end else if (s_axi_arvalid) begin
          s_axi_arready = 1'b1;
          id_d          = s_axi_arid;
          addr_d        = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
          len_d         = s_axi_arlen;
          beat_d        = '0;
          err_d         = 1'b0;
          last_rd_d     = 1'b1;
          state_d       = RD_DATA;
        end
      end
      WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_we = in_range;
          // wlast is only checked; the beat counter alone ends the burst.
          if (!in_range || (s_axi_wlast != is_last)) err_d = 1'b1;
          if (is_last) state_d = WR_RESP;
          else         beat_d  = beat_q + 8'd1;
        end
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = id_q;
        s_axi_bresp  = err_q ? 2'b10 : 2'b00;
        if (s_axi_bready) state_d = IDLE;
      end
      RD_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rid    = id_q;
        s_axi_rdata  = in_range ? mem[midx] : '0;
        s_axi_rresp  = in_range ? 2'b00 : 2'b10;
        s_axi_rlast  = is_last;
        if (s_axi_rready) begin
          if (is_last) state_d = IDLE;
          else         beat_d  = beat_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array write port; mem_we is gated by state, so reset blocks writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef AXI_DATA_MEM_WSTRB_EN
      for (int b = 0; b < NB; b++)
        if (s_axi_wstrb[b]) mem[midx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
`else
      mem[midx] <= s_axi_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_axi_data_mem_slave.sv
// Directed bench for axi_data_mem_slave: reset values, arbitration, single and
// burst transfers, out-of-range beats, wlast mismatch, strobes, mid-burst reset.
module tb_axi_data_mem_slave;
  localparam int AW = 32, DW = 32, IW = 1, MW = 1024;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [IW-1:0] s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [7:0]    s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0]    s_axi_awsize = 3'd2, s_axi_arsize = 3'd2;
  logic [1:0]    s_axi_awburst = 2'b01, s_axi_arburst = 2'b01;
  logic          s_axi_awvalid = 0, s_axi_awready, s_axi_arvalid = 0, s_axi_arready;
  logic [DW-1:0] s_axi_wdata = '0, s_axi_rdata;
  logic [3:0]    s_axi_wstrb = '0;
  logic          s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_wready;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic          s_axi_bvalid, s_axi_bready = 0;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready = 0, slave_busy;

  axi_data_mem_slave #(
    .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ID_WIDTH(IW), .MEM_WORDS(MW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .slave_busy(slave_busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  int          rd_cyc;
  logic [1:0]  bresp_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All phase tasks start and end at posedge+1; outputs sampled at negedge.
  task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awid = 1'b1; s_axi_awvalid = 1;
    @(negedge clk);
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("aw_timeout", n, 0);
    @(posedge clk); #1;
    s_axi_awvalid = 0;
  endtask

  task automatic w_phase(input logic [7:0] len, input logic [31:0] d0, input logic [31:0] inc,
                         input logic [3:0] strb, input int bad);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      s_axi_wvalid = 1; s_axi_wdata = d0 + i * inc; s_axi_wstrb = strb;
      s_axi_wlast  = (i == int'(len)) ^ (i == bad);
      @(negedge clk);
      while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin chk("w_timeout", n, 0); s_axi_wvalid = 0; return; end
      @(posedge clk); #1;
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
  endtask

  task automatic b_phase(output logic [1:0] resp);
    int n;
    n = 0;
    s_axi_bready = 1;
    @(negedge clk);
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("b_timeout", n, 0);
    chk("b_latency", n, 0);
    chk("bid", s_axi_bid, 1);
    resp = s_axi_bresp;
    @(posedge clk); #1;
    s_axi_bready = 0;
  endtask

  task automatic r_phase(input logic [7:0] len, input int abort_at);
    int n;
    rd_cyc = 0;
    s_axi_rready = 1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      @(negedge clk);
      while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin chk("r_timeout", n, 0); s_axi_rready = 0; return; end
      rd_cyc += n + 1;
      if (i == abort_at) begin
        chk("abort_rvalid_before", s_axi_rvalid, 1);
        reset_n = 0; #1;
        chk("abort_rvalid", s_axi_rvalid, 0);
        chk("abort_rlast", s_axi_rlast, 0);
        chk("abort_busy", slave_busy, 0);
        s_axi_rready = 0;
        return;
      end
      if (i == 0) chk("rid", s_axi_rid, 0);
      rd_data[i] = s_axi_rdata; rd_resp[i] = s_axi_rresp; rd_last[i] = s_axi_rlast;
      @(posedge clk); #1;
    end
    s_axi_rready = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0,
                          input logic [31:0] inc, input logic [3:0] strb, input int bad);
    aw_phase(addr, len);
    w_phase(len, d0, inc, strb, bad);
    b_phase(bresp_v);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int abort_at);
    int n;
    n = 0;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = 1'b0; s_axi_arvalid = 1;
    @(negedge clk);
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ar_timeout", n, 0);
    @(posedge clk); #1;
    s_axi_arvalid = 0;
    r_phase(len, abort_at);
  endtask

  initial begin
    // reset values while reset_n is low
    #1;
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_rlast",  s_axi_rlast, 0);
    chk("rst_busy",   slave_busy, 0);
    chk("rst_rdata",  s_axi_rdata, 0);
    chk("rst_bresp",  s_axi_bresp, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // first tie after reset goes to write
    s_axi_awaddr = 32'h100; s_axi_awlen = 0; s_axi_awid = 1; s_axi_awvalid = 1;
    s_axi_araddr = 32'h100; s_axi_arlen = 0; s_axi_arid = 0; s_axi_arvalid = 1;
    @(negedge clk);
    chk("tie1_awready", s_axi_awready, 1);
    chk("tie1_arready", s_axi_arready, 0);
    @(posedge clk); #1;
    s_axi_awvalid = 0;
    @(negedge clk);
    chk("wready_after_aw", s_axi_wready, 1);
    @(posedge clk); #1;
    w_phase(0, 32'hA5A5A5A5, 0, 4'hF, -1);
    b_phase(bresp_v);
    chk("tie1_bresp", bresp_v, 0);
    // second tie goes to read (last served was write)
    s_axi_awvalid = 1;
    @(negedge clk);
    chk("tie2_arready", s_axi_arready, 1);
    chk("tie2_awready", s_axi_awready, 0);
    @(posedge clk); #1;
    s_axi_awvalid = 0; s_axi_arvalid = 0;
    r_phase(0, -1);
    chk("tie2_rdata", rd_data[0], 32'hA5A5A5A5);

    // single beat write/read
    do_write(32'h10, 0, 32'hDEADBEEF, 0, 4'hF, -1);
    chk("single_bresp", bresp_v, 0);
    do_read(32'h10, 0, -1);
    chk("single_rdata", rd_data[0], 32'hDEADBEEF);
    chk("single_rresp", rd_resp[0], 0);
    chk("single_rlast", rd_last[0], 1);

    // 16-beat burst
    do_write(32'h40, 15, 0, 1, 4'hF, -1);
    chk("burst_bresp", bresp_v, 0);
    do_read(32'h40, 15, -1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("burst_rdata%0d", i), rd_data[i], i);
      chk($sformatf("burst_rlast%0d", i), rd_last[i], (i == 15));
    end
    chk("burst_cycles", rd_cyc, 16);

    // out of range: first word past the array
    do_write(MW * 4, 0, 32'h55AA55AA, 0, 4'hF, -1);
    chk("oor_bresp", bresp_v, 2'b10);
    do_read(MW * 4, 0, -1);
    chk("oor_rdata", rd_data[0], 0);
    chk("oor_rresp", rd_resp[0], 2'b10);
    do_read(32'h0, 0, -1);
    chk("oor_no_alias", rd_data[0], 0);

    // burst straddling the end of the array
    do_write((MW - 2) * 4, 3, 32'hC0, 1, 4'hF, -1);
    chk("edge_bresp", bresp_v, 2'b10);
    do_read((MW - 2) * 4, 3, -1);
    chk("edge_d0", rd_data[0], 32'hC0);
    chk("edge_d1", rd_data[1], 32'hC1);
    chk("edge_d2", rd_data[2], 0);
    chk("edge_r1", rd_resp[1], 0);
    chk("edge_r2", rd_resp[2], 2'b10);
    chk("edge_r3", rd_resp[3], 2'b10);
    chk("edge_last3", rd_last[3], 1);

    // wlast on wrong beat: data still written, SLVERR
    do_write(32'h500, 1, 32'h77, 1, 4'hF, 0);
    chk("wlast_bresp", bresp_v, 2'b10);
    do_read(32'h500, 1, -1);
    chk("wlast_d0", rd_data[0], 32'h77);
    chk("wlast_d1", rd_data[1], 32'h78);

    // strobes
    do_write(32'h200, 0, 32'hFFFFFFFF, 0, 4'hF, -1);
    do_write(32'h200, 0, 32'h12345678, 0, 4'b0011, -1);
    do_read(32'h200, 0, -1);
`ifdef AXI_DATA_MEM_WSTRB_EN
    chk("strb_0011", rd_data[0], 32'hFFFF5678);
`else
    chk("strb_0011", rd_data[0], 32'h12345678);
`endif
    do_write(32'h200, 0, 32'hAAAAAAAA, 0, 4'b0000, -1);
    do_read(32'h200, 0, -1);
`ifdef AXI_DATA_MEM_WSTRB_EN
    chk("strb_0000", rd_data[0], 32'hFFFF5678);
`else
    chk("strb_0000", rd_data[0], 32'hAAAAAAAA);
`endif

    // reset during beat 3 of an 8-beat read
    do_write(32'h300, 7, 32'h1000, 32'h11, 4'hF, -1);
    do_read(32'h300, 7, 3);
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    chk("post_rst_busy", slave_busy, 0);
    @(posedge clk); #1;
    do_read(32'h300, 7, -1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("post_rst_d%0d", i), rd_data[i], 32'h1000 + i * 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
